// File: rtl/eth_frame_source.sv
// FIFO-backed RMII transmit source: buffers words, then serialises them MSB-dibit-first
// as a valid/data stream, optionally recirculating the frame, with an inter-frame gap.
module eth_frame_source #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 8,
  parameter  int GAP_CYCLES = 48,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  start,
  input  logic                  repeat_en,
  output logic                  axiov,
  output logic [1:0]            axiod,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CW-1:0]         count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int NDB = DATA_WIDTH / 2;
  localparam int DCW = $clog2(NDB + 1);
  localparam int GW  = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         len_q, len_d;
  logic [CW-1:0]         words_left_q, words_left_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DCW-1:0]        dibit_q, dibit_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  rep_q, rep_d;
  logic                  axiov_q, axiov_d;
  logic [1:0]            axiod_q, axiod_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;

  logic                  push, pop;
  logic                  mem_we;
  logic [PW-1:0]         mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] rd_word;

  assign wr_ready   = (state_q == IDLE) && (count_q < CW'(DEPTH));
  assign axiov      = axiov_q;
  assign axiod      = axiod_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign count      = count_q;
  assign rd_word    = mem_q[rd_ptr_q];
  assign push       = wr_valid && wr_ready;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    words_left_d = words_left_q;
    shift_d      = shift_q;
    dibit_d      = dibit_q;
    gap_d        = gap_q;
    rep_d        = rep_q;
    axiov_d      = axiov_q;
    axiod_d      = axiod_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    pop          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && ((count_q != '0) || push)) begin
          len_d   = count_q + CW'(push);
          rep_d   = repeat_en;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // First dibit is presented on the same edge the word leaves the FIFO.
        pop          = 1'b1;
        axiov_d      = 1'b1;
        axiod_d      = rd_word[DATA_WIDTH-1 -: 2];
        shift_d      = rd_word << 2;
        dibit_d      = DCW'(1);
        words_left_d = len_q - CW'(1);
        state_d      = SEND;
      end
      SEND: begin
        if (dibit_q == DCW'(NDB)) begin
          if (words_left_q != '0) begin
            pop          = 1'b1;
            axiod_d      = rd_word[DATA_WIDTH-1 -: 2];
            shift_d      = rd_word << 2;
            dibit_d      = DCW'(1);
            words_left_d = words_left_q - CW'(1);
          end else begin
            axiov_d      = 1'b0;
            axiod_d      = 2'b00;
            frame_done_d = 1'b1;
            gap_d        = GW'(GAP_CYCLES - 1);
            state_d      = GAP;
          end
        end else begin
          axiod_d = shift_q[DATA_WIDTH-1 -: 2];
          shift_d = shift_q << 2;
          dibit_d = dibit_q + DCW'(1);
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          rep_d = rep_q & repeat_en;
          if (rep_q && repeat_en) begin
            state_d = LOAD;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Push and pop never coincide: pushes only happen in IDLE, pops only while busy.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q;
    mem_wdata = wr_data;
    if (push) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + PW'(1);
      count_d  = count_q + CW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (rep_q) begin
        mem_we    = 1'b1;
        mem_wdata = rd_word;
        wr_ptr_d  = wr_ptr_q + PW'(1);
      end else begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      len_q        <= '0;
      words_left_q <= '0;
      shift_q      <= '0;
      dibit_q      <= '0;
      gap_q        <= '0;
      rep_q        <= 1'b0;
      axiov_q      <= 1'b0;
      axiod_q      <= 2'b00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      len_q        <= len_d;
      words_left_q <= words_left_d;
      shift_q      <= shift_d;
      dibit_q      <= dibit_d;
      gap_q        <= gap_d;
      rep_q        <= rep_d;
      axiov_q      <= axiov_d;
      axiod_q      <= axiod_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_eth_frame_source.sv
// Scoreboard bench for eth_frame_source: expected dibits are queued when a frame is
// started and compared as the stream comes out; frame timing is measured per test.
module tb_eth_frame_source;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int GAP   = 48;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int NDB   = DW / 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          start;
  logic          repeat_en;
  logic          axiov;
  logic [1:0]    axiod;
  logic          busy;
  logic          frame_done;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mdl[$];
  logic [1:0]    exp_q[$];
  logic [1:0]    exp_d;

  eth_frame_source #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .start(start), .repeat_en(repeat_en), .axiov(axiov), .axiod(axiod), .busy(busy),
    .frame_done(frame_done), .count(count)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && axiov) begin
      if (exp_q.size() == 0) chk("unexpected_valid", 32'(axiov), 32'd0);
      else begin
        exp_d = exp_q.pop_front();
        chk("dibit", 32'(axiod), 32'(exp_d));
      end
    end
  end

  task automatic expect_frame(input bit rep);
    logic [DW-1:0] w;
    foreach (mdl[i]) begin
      w = mdl[i];
      for (int j = NDB - 1; j >= 0; j--) exp_q.push_back(w[2*j +: 2]);
    end
    if (!rep) mdl.delete();
  endtask

  task automatic wr(input logic [DW-1:0] w, input bit exp_rdy);
    @(posedge clk); #1;
    chk("wr_ready", 32'(wr_ready), 32'(exp_rdy));
    wr_valid = 1'b1;
    wr_data  = w;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    if (exp_rdy) mdl.push_back(w);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called right after start was sampled; k counts cycles after the start cycle.
  task automatic frame_timing(input string tag, input int len);
    int first = -1, last = -1, done = -1, fall = -1, nv = 0;
    for (int k = 1; k <= len * NDB + GAP + 10; k++) begin
      @(negedge clk);
      if (k == 1) chk({tag, "_busy_t1"}, 32'(busy), 32'd1);
      if (axiov) begin
        if (first < 0) first = k;
        last = k;
        nv++;
      end
      if (frame_done && done < 0) done = k;
      if (!busy) begin
        fall = k;
        break;
      end
    end
    chk({tag, "_first_valid"}, first, 2);
    chk({tag, "_valid_cycles"}, nv, len * NDB);
    chk({tag, "_last_valid"}, last, 1 + len * NDB);
    chk({tag, "_frame_done"}, done, 2 + len * NDB);
    chk({tag, "_busy_fall"}, fall, 2 + len * NDB + GAP);
    chk({tag, "_count"}, 32'(count), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, nv, nr, nf, nd, bf;
    int rise[4], fall[4], done[4];
    bit pv;

    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; start = 1'b0; repeat_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_axiov", 32'(axiov), 32'd0);
    chk("rst_axiod", 32'(axiod), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);

    // single word
    wr(32'hFEED_BEEF, 1'b1);
    expect_frame(1'b0);
    pulse_start();
    frame_timing("single", 1);

    // back-to-back words
    wr(32'h0000_0000, 1'b1);
    wr(32'hFFFF_FFFF, 1'b1);
    expect_frame(1'b0);
    pulse_start();
    frame_timing("b2b", 2);

    // start with a simultaneous write into an empty FIFO
    @(posedge clk); #1;
    chk("sw_ready", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1; wr_data = 32'h8421_C3A5; start = 1'b1;
    mdl.push_back(32'h8421_C3A5);
    expect_frame(1'b0);
    @(posedge clk); #1;
    wr_valid = 1'b0; start = 1'b0;
    frame_timing("start_wr", 1);

    // repeat, then drop repeat_en during frame 2
    wr(32'h1234_5678, 1'b1);
    wr(32'h9ABC_DEF0, 1'b1);
    wr(32'h0F1E_2D3C, 1'b1);
    expect_frame(1'b1);
    repeat_en = 1'b1;
    pulse_start();
    bad = 0; nr = 0; nf = 0; nd = 0; bf = -1; pv = 1'b0;
    for (int i = 0; i < 4; i++) begin rise[i] = -1; fall[i] = -1; done[i] = -1; end
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (count != CW'(3)) bad++;
      if (axiov && !pv && nr < 4) begin rise[nr] = k; nr++; end
      if (!axiov && pv && nf < 4) begin fall[nf] = k; nf++; end
      if (frame_done && nd < 4) begin
        done[nd] = k; nd++;
        if (nd == 1) expect_frame(1'b1);
      end
      if (axiov && nr == 2 && k == rise[1] + 9) repeat_en = 1'b0;
      pv = axiov;
      if (!busy) begin bf = k; break; end
    end
    chk("rep_rise0", rise[0], 2);
    chk("rep_fall0", fall[0], 50);
    chk("rep_done0", done[0], 50);
    chk("rep_gap", rise[1] - fall[0], GAP + 1);
    chk("rep_fall1", fall[1], 147);
    chk("rep_done1", done[1], 147);
    chk("rep_frames", nr, 2);
    chk("rep_busy_fall", bf, 147 + GAP);
    chk("rep_count_bad_cycles", bad, 0);
    chk("rep_count_after", 32'(count), 32'd3);
    expect_frame(1'b0);
    pulse_start();
    frame_timing("drain", 3);

    // fill beyond DEPTH
    for (int i = 0; i < DEPTH + 1; i++)
      wr(32'hC0DE_0000 + 32'(i * 32'h1111), mdl.size() < DEPTH);
    chk("full_count", 32'(count), 32'(DEPTH));
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    expect_frame(1'b0);
    pulse_start();
    frame_timing("full", DEPTH);

    // start with an empty FIFO
    pulse_start();
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy || frame_done || axiov) bad++;
    end
    chk("empty_start", bad, 0);

    // start and write while busy are ignored
    wr(32'h5A5A_A5A5, 1'b1);
    expect_frame(1'b0);
    pulse_start();
    repeat (4) @(negedge clk);
    wr(32'hDEAD_0001, 1'b0);
    pulse_start();
    bf = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) begin bf = k; break; end
    end
    chk("busy_ign_done", 32'(bf >= 0), 32'd1);
    bad = 0;
    repeat (70) begin
      @(negedge clk);
      if (busy || axiov) bad++;
    end
    chk("busy_ign_no_refire", bad, 0);
    chk("busy_ign_count", 32'(count), 32'd0);

    // pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) wr({8'(r), 8'(i), 16'hA55A} ^ 32'h3C00_0F00, 1'b1);
      expect_frame(1'b0);
      pulse_start();
      frame_timing("wrap", 5);
    end

    // reset mid-frame
    wr(32'hA5C3_0F69, 1'b1);
    wr(32'h7E81_4422, 1'b1);
    expect_frame(1'b0);
    pulse_start();
    nv = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (axiov) nv++;
      if (nv == 10) break;
    end
    chk("mid_nv", nv, 10);
    chk("mid_count_before", 32'(count), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_axiov", 32'(axiov), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    mdl.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wr(32'h1357_9BDF, 1'b1);
    expect_frame(1'b0);
    pulse_start();
    frame_timing("after_rst", 1);

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
